// File: rtl/core_shift_iter.sv
// core_shift_iter: iterative register-amount barrel shifter (LSL/LSR/ASR/ROR)
// feeding the ALU b operand and shifter carry-out. Shifts up to STEP bits per
// cycle. Optional RRX support is compiled in with `define CORE_SHIFTER_RRX_EN.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// SHIFT | applying up to STEP bits per cycle until rem reaches 0
// DONE  | q/c valid and held until out_ready
module core_shift_iter #(
    parameter int W    = 32,
    parameter int STEP = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   shift_op,
    input  logic         rrx,
    input  logic [W-1:0] value,
    input  logic [7:0]   amount,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q,
    output logic         c
);

    localparam int RW = $clog2(W) + 1;
    localparam int LW = $clog2(W);
    localparam logic [RW-1:0] STEP_R = RW'(STEP);
    localparam logic [RW-1:0] W_R    = RW'(W);
    localparam logic [8:0]    W_A    = 9'(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   data_r, init_data, step_data;
    logic           cry_r, init_cry, step_cry;
    logic [RW-1:0]  rem_r, init_rem, rem_nxt;
    logic [1:0]     op_r;
    logic           clr_r, init_clr;
    logic           last_step;

    // Effective amount, starting data/carry and end-carry rule for a new request
    always_comb begin
        init_data = value;
        init_cry  = c_in;
        init_rem  = '0;
        init_clr  = 1'b0;
        if (amount != 8'd0) begin
            case (shift_op)
                2'd0, 2'd1: begin
                    if ({1'b0, amount} > W_A) begin
                        init_rem = W_R;
                        init_clr = 1'b1;
                    end else begin
                        init_rem = amount[RW-1:0];
                    end
                end
                2'd2: init_rem = ({1'b0, amount} >= W_A) ? W_R : amount[RW-1:0];
                default: begin
                    init_rem = {1'b0, amount[LW-1:0]};
                    // Rotation by a whole multiple of W: value unchanged, carry is the top bit
                    if (amount[LW-1:0] == '0) init_cry = value[W-1];
                end
            endcase
        end
`ifdef CORE_SHIFTER_RRX_EN
        if (rrx) begin
            init_data = {c_in, value[W-1:1]};
            init_cry  = value[0];
            init_rem  = '0;
            init_clr  = 1'b0;
        end
`endif
    end

`ifndef CORE_SHIFTER_RRX_EN
    logic unused_rrx;
    assign unused_rrx = rrx;
`endif

    // One iteration: up to STEP single-bit shifts, carry tracks the last bit out
    always_comb begin
        step_data = data_r;
        step_cry  = cry_r;
        for (int k = 0; k < STEP; k++) begin
            if (RW'(k) < rem_r) begin
                case (op_r)
                    2'd0: begin
                        step_cry  = step_data[W-1];
                        step_data = {step_data[W-2:0], 1'b0};
                    end
                    2'd1: begin
                        step_cry  = step_data[0];
                        step_data = {1'b0, step_data[W-1:1]};
                    end
                    2'd2: begin
                        step_cry  = step_data[0];
                        step_data = {step_data[W-1], step_data[W-1:1]};
                    end
                    default: begin
                        step_cry  = step_data[0];
                        step_data = {step_data[0], step_data[W-1:1]};
                    end
                endcase
            end
        end
        rem_nxt   = (rem_r > STEP_R) ? rem_r - STEP_R : '0;
        last_step = (rem_r <= STEP_R);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; flush overrides everything but reset
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Working datapath and result registers; q/c only change on entry to DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r <= '0;
            cry_r  <= 1'b0;
            rem_r  <= '0;
            op_r   <= 2'd0;
            clr_r  <= 1'b0;
            q      <= '0;
            c      <= 1'b0;
        end else if (!flush) begin
            if (state == IDLE && in_valid) begin
                data_r <= init_data;
                cry_r  <= init_cry;
                rem_r  <= init_rem;
                op_r   <= shift_op;
                clr_r  <= init_clr;
            end else if (state == SHIFT) begin
                data_r <= step_data;
                cry_r  <= step_cry;
                rem_r  <= rem_nxt;
                if (last_step) begin
                    q <= step_data;
                    c <= clr_r ? 1'b0 : step_cry;
                end
            end
        end
    end

endmodule
